// File: rtl/pipelined_multiplier_array_pkg.sv
// Shared defaults and mode encodings for the lane-parallel fixed-point multiplier.
// Imported by the interface, the lane rescaler and the top.
package pipelined_multiplier_array_pkg;

  localparam int unsigned DefDataWidth  = 16;
  localparam int unsigned DefFracBit    = 8;
  localparam int unsigned DefKernelSize = 5;

  typedef enum logic {
    RoundTrunc  = 1'b0,
    RoundHalfUp = 1'b1
  } round_mode_e;

  typedef enum logic {
    OvfWrap = 1'b0,
    OvfSat  = 1'b1
  } ovf_mode_e;

endpackage

// File: rtl/pipelined_multiplier_array_if.sv
// Valid/ready operand, result and overflow-status bundle of the multiplier array.
// The master side drives operands, modes, out_ready and ovf_clr.
interface pipelined_multiplier_array_if
  import pipelined_multiplier_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned LANES      = DefKernelSize * DefKernelSize
);

  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] weights;
  logic [LANES*DATA_WIDTH-1:0] pixel_data;
  logic                        round_en;
  logic                        sat_en;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] result;
  logic [LANES-1:0]            lane_ovf;
  logic                        ovf_sticky;
  logic                        ovf_clr;

  modport master (
    output in_valid, weights, pixel_data, round_en, sat_en, out_ready, ovf_clr,
    input  in_ready, out_valid, result, lane_ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, weights, pixel_data, round_en, sat_en, out_ready, ovf_clr,
    output in_ready, out_valid, result, lane_ovf, ovf_sticky
  );

endinterface

// File: rtl/pipelined_multiplier_array_lane_rescale.sv
// Combinational round / arithmetic-shift / saturate of one full-width signed product
// down to DATA_WIDTH bits, with an overflow flag that is reported in both modes.
module pipelined_multiplier_array_lane_rescale
  import pipelined_multiplier_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned FRAC_BIT   = DefFracBit
) (
  input  logic [2*DATA_WIDTH-1:0] p,
  input  round_mode_e             round_en,
  input  ovf_mode_e               sat_en,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    ovf
);

  // One guard bit so that adding the rounding constant never wraps.
  localparam int unsigned ExtWidth = 2 * DATA_WIDTH + 1;
  localparam logic [ExtWidth-1:0] Half = {{(ExtWidth-1){1'b0}}, 1'b1} << (FRAC_BIT - 1);
  localparam logic [DATA_WIDTH-1:0] MaxPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ExtWidth-1:0]   p_ext;
  logic signed [ExtWidth-1:0]   p_rnd;
  logic signed [ExtWidth-1:0]   s;
  logic [ExtWidth-DATA_WIDTH:0] hi;

  always_comb begin
    p_ext = {p[2*DATA_WIDTH-1], p};
    p_rnd = p_ext + ((round_en == RoundHalfUp) ? Half : '0);
    s     = p_rnd >>> FRAC_BIT;
    // In range only if every bit above the result sign bit matches it.
    hi    = s[ExtWidth-1:DATA_WIDTH-1];
    ovf   = !((&hi) || !(|hi));
    if (ovf && (sat_en == OvfSat)) begin
      result = s[ExtWidth-1] ? MinNeg : MaxPos;
    end else begin
      result = s[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pipelined_multiplier_array.sv
// Two-stage valid/ready signed fixed-point multiplier array: S1 holds exact products and
// per-beat modes, S2 holds rescaled results and lane overflow; sticky overflow to control.
module pipelined_multiplier_array
  import pipelined_multiplier_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned FRAC_BIT    = DefFracBit,
  parameter int unsigned KERNEL_SIZE = DefKernelSize,
  parameter int unsigned LANES       = KERNEL_SIZE * KERNEL_SIZE
) (
  input logic                        clk,
  input logic                        rst_n,
  pipelined_multiplier_array_if.slave bus
);

  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;

  logic [LANES-1:0][ProdWidth-1:0]  prod;
  logic [LANES-1:0][ProdWidth-1:0]  s1_prod_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] rescaled;
  logic [LANES-1:0]                 rescaled_ovf;
  logic [LANES-1:0][DATA_WIDTH-1:0] result_q;
  logic [LANES-1:0]                 lane_ovf_q;

  logic        s1_valid_q, s2_valid_q;
  round_mode_e s1_round_q;
  ovf_mode_e   s1_sat_q;
  logic        s1_load, s2_load;
  logic        sticky_q, sticky_d;

  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid_q || s2_load;
  assign bus.in_ready = s1_load;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] w, x;
    assign w = bus.weights[i*DATA_WIDTH +: DATA_WIDTH];
    assign x = bus.pixel_data[i*DATA_WIDTH +: DATA_WIDTH];
    // Sign-extended operands: the low ProdWidth bits are the exact signed product.
    assign prod[i] = {{DATA_WIDTH{w[DATA_WIDTH-1]}}, w} * {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};

    pipelined_multiplier_array_lane_rescale #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BIT  (FRAC_BIT)
    ) u_rescale (
      .p       (s1_prod_q[i]),
      .round_en(s1_round_q),
      .sat_en  (s1_sat_q),
      .result  (rescaled[i]),
      .ovf     (rescaled_ovf[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_round_q <= RoundTrunc;
      s1_sat_q   <= OvfWrap;
    end else if (s1_load) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_prod_q  <= prod;
        s1_round_q <= round_mode_e'(bus.round_en);
        s1_sat_q   <= ovf_mode_e'(bus.sat_en);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      lane_ovf_q <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q   <= rescaled;
        lane_ovf_q <= rescaled_ovf;
      end
    end
  end

  // A set in the same cycle as a clear takes priority.
  always_comb begin
    sticky_d = sticky_q;
    if (s2_valid_q && bus.out_ready && (|lane_ovf_q)) begin
      sticky_d = 1'b1;
    end else if (bus.ovf_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.result     = result_q;
  assign bus.lane_ovf   = lane_ovf_q;
  assign bus.ovf_sticky = sticky_q;

endmodule
